// File: rtl/cd_csr_mover.sv
// Frame mover between the CDBUS CSR port and local RX/TX frame buffers.
// Sole CSR master; RX and TX jobs are granted round-robin and never overlap.
module cd_csr_mover #(
  parameter int MAX_LEN    = 253,
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [4:0] csr_address,
  output logic       csr_read,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  input  logic [7:0] csr_readdata,
  input  logic       rx_pending,
  input  logic       tx_ram_full,
  output logic       rxb_wr_en,
  output logic [7:0] rxb_wr_addr,
  output logic [7:0] rxb_wr_data,
  output logic       rx_frame_valid,
  output logic [7:0] rx_frame_len,
  output logic       rx_overflow,
  input  logic       rx_frame_ack,
  input  logic       tx_req,
  input  logic [7:0] tx_len,
  output logic       tx_ack,
  output logic [7:0] txb_rd_addr,
  input  logic [7:0] txb_rd_data,
  output logic       tx_done,
  output logic       busy
);

  localparam logic [4:0] A_RX_LEN  = 5'h14;
  localparam logic [4:0] A_DAT     = 5'h15;
  localparam logic [4:0] A_CTRL    = 5'h16;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RX_START, S_RX_LEN, S_RX_DAT, S_RX_DONE,
    S_TX_START, S_TX_FETCH, S_TX_WR, S_TX_COMMIT, S_SETTLE
  } state_t;

  state_t     state, state_nx;
  logic [7:0] len, cnt, settle_cnt;
  logic       last_rx, ovf_q;
  logic       rx_elig, tx_elig, grant_rx, grant_tx;

  // On a tie the side that was not served last wins.
  assign rx_elig  = rx_pending & ~rx_frame_valid;
  assign tx_elig  = tx_req & ~tx_ram_full;
  assign grant_rx = rx_elig & (~tx_elig | ~last_rx);
  assign grant_tx = tx_elig & (~rx_elig | last_rx);

  always_comb begin
    state_nx      = state;
    csr_address   = 5'd0;
    csr_read      = 1'b0;
    csr_write     = 1'b0;
    csr_writedata = 8'd0;
    rxb_wr_en     = 1'b0;
    rxb_wr_addr   = 8'd0;
    rxb_wr_data   = 8'd0;
    txb_rd_addr   = 8'd0;
    tx_ack        = 1'b0;
    tx_done       = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (grant_rx)      state_nx = S_RX_START;
        else if (grant_tx) state_nx = S_TX_START;
      end
      S_RX_START: begin
        csr_write   = 1'b1;
        csr_address = A_CTRL;
        state_nx    = S_RX_LEN;
      end
      S_RX_LEN: begin
        csr_read    = 1'b1;
        csr_address = A_RX_LEN;
        state_nx    = (csr_readdata == 8'd0) ? S_RX_DONE : S_RX_DAT;
      end
      S_RX_DAT: begin
        csr_read    = 1'b1;
        csr_address = A_DAT;
        rxb_wr_en   = 1'b1;
        rxb_wr_addr = cnt;
        rxb_wr_data = csr_readdata;
        if (cnt == len - 8'd1) state_nx = S_RX_DONE;
      end
      S_RX_DONE: begin
        csr_write     = 1'b1;
        csr_address   = A_CTRL;
        csr_writedata = 8'h10;
        state_nx      = S_SETTLE;
      end
      S_TX_START: begin
        // Entered only from a TX grant, so this is the acceptance pulse.
        tx_ack = 1'b1;
        if (len == 8'd0) begin
          tx_done  = 1'b1;
          state_nx = S_SETTLE;
        end else begin
          csr_write   = 1'b1;
          csr_address = A_CTRL;
          state_nx    = S_TX_FETCH;
        end
      end
      S_TX_FETCH: begin
        txb_rd_addr = cnt;
        state_nx    = S_TX_WR;
      end
      S_TX_WR: begin
        csr_write     = 1'b1;
        csr_address   = A_DAT;
        csr_writedata = txb_rd_data;
        state_nx      = (cnt == len - 8'd1) ? S_TX_COMMIT : S_TX_FETCH;
      end
      S_TX_COMMIT: begin
        csr_write     = 1'b1;
        csr_address   = A_CTRL;
        csr_writedata = 8'h01;
        tx_done       = 1'b1;
        state_nx      = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b0;
        if (settle_cnt == SETTLE_LAST) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      len            <= 8'd0;
      cnt            <= 8'd0;
      settle_cnt     <= 8'd0;
      last_rx        <= 1'b0;
      ovf_q          <= 1'b0;
      rx_frame_valid <= 1'b0;
      rx_frame_len   <= 8'd0;
      rx_overflow    <= 1'b0;
    end else begin
      state      <= state_nx;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      case (state)
        S_IDLE: begin
          if (grant_rx) begin
            last_rx <= 1'b1;
          end else if (grant_tx) begin
            last_rx <= 1'b0;
            len     <= tx_len;
            cnt     <= 8'd0;
          end
        end
        S_RX_LEN: begin
          cnt <= 8'd0;
          if (csr_readdata > MAX_LEN_B) begin
            len   <= MAX_LEN_B;
            ovf_q <= 1'b1;
          end else begin
            len   <= csr_readdata;
            ovf_q <= 1'b0;
          end
        end
        S_RX_DAT, S_TX_WR: cnt <= cnt + 8'd1;
        default: ;
      endcase
      // Publishing a new frame takes priority over a release in the same cycle.
      if (state == S_RX_DONE) begin
        rx_frame_valid <= 1'b1;
        rx_frame_len   <= len;
        rx_overflow    <= ovf_q;
      end else if (rx_frame_ack && rx_frame_valid) begin
        rx_frame_valid <= 1'b0;
        rx_overflow    <= 1'b0;
      end
    end
  end

endmodule
